// File: rtl/score_pkg.sv
// ============================================================================
// Module      : score_pkg
// Description : Shared defaults, index-width helper and FSM state encoding
//               for the high-score rank controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package score_pkg;

    localparam int DEPTH_DEF   = 5;
    localparam int SCORE_W_DEF = 10;

    // Index must also encode DEPTH itself ("not placed" / out of range).
    function automatic int calc_idx_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        SHIFT = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/score_table.sv
// ============================================================================
// Module      : score_table
// Description : DEPTH x SCORE_W score register array with single-entry shift,
//               write port, synchronous clear and two asynchronous read ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_table
    import score_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int IDX_W   = calc_idx_w(DEPTH_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_shift_en,
    input  logic [IDX_W-1:0]   i_shift_idx,
    input  logic               i_wr_en,
    input  logic [IDX_W-1:0]   i_wr_idx,
    input  logic [SCORE_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]   i_rd_idx,
    output logic [SCORE_W-1:0] o_rd_data,
    input  logic [IDX_W-1:0]   i_cmp_idx,
    output logic [SCORE_W-1:0] o_cmp_data
);

    logic [SCORE_W-1:0] r_tbl [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tbl[i] <= '0;
            end
        end else begin
            // Entry i takes entry i-1; entry 0 is only ever written directly.
            for (int i = 1; i < DEPTH; i++) begin
                if (i_shift_en && (i_shift_idx == IDX_W'(i))) begin
                    r_tbl[i] <= r_tbl[i-1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (i_wr_en && (i_wr_idx == IDX_W'(i))) begin
                    r_tbl[i] <= i_wr_data;
                end
            end
        end
    end

    // Indices at or beyond DEPTH read as zero.
    always_comb begin
        o_rd_data  = '0;
        o_cmp_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_rd_idx == IDX_W'(i)) begin
                o_rd_data = r_tbl[i];
            end
            if (i_cmp_idx == IDX_W'(i)) begin
                o_cmp_data = r_tbl[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/score_rank_ctrl.sv
// ============================================================================
// Module      : score_rank_ctrl
// Description : Inserts a final score into a sorted top-DEPTH table one step
//               per clock and serves combinational table reads.
//               Optional macro SCORE_CLEAR_EN adds an IDLE-only table clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_rank_ctrl
    import score_pkg::*;
#(
    parameter int  DEPTH   = DEPTH_DEF,
    parameter int  SCORE_W = SCORE_W_DEF,
    localparam int IDX_W   = calc_idx_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               record,
    input  logic [SCORE_W-1:0] score,
`ifdef SCORE_CLEAR_EN
    input  logic               clear,
`endif
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [SCORE_W-1:0] rd_score,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   rank,
    output logic               new_best
);

    localparam logic [IDX_W-1:0] C_LAST  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] C_DEPTH = IDX_W'(DEPTH);
    localparam logic [IDX_W-1:0] C_ONE   = IDX_W'(1);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_record_q;
    logic [SCORE_W-1:0] r_cur;
    logic [IDX_W-1:0]   r_pos;
    logic [IDX_W-1:0]   r_j;
    logic [IDX_W-1:0]   r_rank;
    logic               r_new_best;

    logic               w_start;
    logic               w_clear;
    logic               w_gt;
    logic               w_shift_en;
    logic               w_wr_en;
    logic [SCORE_W-1:0] w_cmp_data;

    assign w_start = record & ~r_record_q;

`ifdef SCORE_CLEAR_EN
    assign w_clear = clear & (r_state == IDLE);
`else
    assign w_clear = 1'b0;
`endif

    // Strict compare: ties land below the existing entry, zero never places.
    assign w_gt = (r_cur > w_cmp_data);

    always_comb begin
        w_next_state = r_state;
        w_shift_en   = 1'b0;
        w_wr_en      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_clear && w_start) begin
                    w_next_state = SCAN;
                end
            end
            SCAN: begin
                if (w_gt) begin
                    w_next_state = (r_pos == C_LAST) ? WRITE : SHIFT;
                end else if (r_pos == C_LAST) begin
                    w_next_state = DONE;
                end
            end
            SHIFT: begin
                w_shift_en = 1'b1;
                if (r_j == (r_pos + C_ONE)) begin
                    w_next_state = WRITE;
                end
            end
            WRITE: begin
                w_wr_en      = 1'b1;
                w_next_state = DONE;
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_record_q <= 1'b0;
            r_cur      <= '0;
            r_pos      <= '0;
            r_j        <= '0;
            r_rank     <= C_DEPTH;
            r_new_best <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_record_q <= record;
            case (r_state)
                IDLE: begin
                    if (w_clear) begin
                        r_rank     <= C_DEPTH;
                        r_new_best <= 1'b0;
                    end else if (w_start) begin
                        r_cur <= score;
                        r_pos <= '0;
                    end
                end
                SCAN: begin
                    if (w_gt) begin
                        r_j <= C_LAST;
                    end else if (r_pos == C_LAST) begin
                        r_rank     <= C_DEPTH;
                        r_new_best <= 1'b0;
                    end else begin
                        r_pos <= r_pos + C_ONE;
                    end
                end
                SHIFT: begin
                    r_j <= r_j - C_ONE;
                end
                WRITE: begin
                    r_rank     <= r_pos;
                    r_new_best <= (r_pos == '0);
                end
                default: begin
                end
            endcase
        end
    end

    score_table #(
        .DEPTH   (DEPTH),
        .SCORE_W (SCORE_W),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_shift_en  (w_shift_en),
        .i_shift_idx (r_j),
        .i_wr_en     (w_wr_en),
        .i_wr_idx    (r_pos),
        .i_wr_data   (r_cur),
        .i_rd_idx    (rd_idx),
        .o_rd_data   (rd_score),
        .i_cmp_idx   (r_pos),
        .o_cmp_data  (w_cmp_data)
    );

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign rank     = r_rank;
    assign new_best = r_new_best;

endmodule

`default_nettype wire

// File: tb/tb_score_rank_ctrl.sv
// ============================================================================
// Module      : tb_score_rank_ctrl
// Description : Directed self-checking bench for score_rank_ctrl (DEPTH=5,
//               SCORE_W=10); clear scenarios built when SCORE_CLEAR_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_rank_ctrl;

    localparam int DEPTH   = 5;
    localparam int SCORE_W = 10;
    localparam int IDX_W   = 3;

    logic               clk;
    logic               rst;
    logic               record;
    logic [SCORE_W-1:0] score;
`ifdef SCORE_CLEAR_EN
    logic               clear;
`endif
    logic [IDX_W-1:0]   rd_idx;
    logic [SCORE_W-1:0] rd_score;
    logic               busy;
    logic               done;
    logic [IDX_W-1:0]   rank;
    logic               new_best;

    int n_checks = 0;
    int n_fail   = 0;

    score_rank_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .record   (record),
        .score    (score),
`ifdef SCORE_CLEAR_EN
        .clear    (clear),
`endif
        .rd_idx   (rd_idx),
        .rd_score (rd_score),
        .busy     (busy),
        .done     (done),
        .rank     (rank),
        .new_best (new_best)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        record = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Raise record for one cycle, count cycles until done, then settle in IDLE.
    task automatic run_record(input logic [SCORE_W-1:0] s, output int lat);
        record = 1'b1;
        score  = s;
        lat    = 0;
        while (lat < 40) begin
            tick();
            lat++;
            if (lat == 1) record = 1'b0;
            if (done === 1'b1) break;
        end
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            rd_idx = IDX_W'(i);
            #1;
            n_checks++;
            if (rd_score !== 10'd0) begin
                n_fail++;
                $display("FAIL reset_rd[%0d]: got %0d expected 0", i, rd_score);
            end
        end
        n_checks++;
        if (rank !== 3'd5 || busy !== 1'b0 || done !== 1'b0 || new_best !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: rank=%0d busy=%b done=%b nb=%b expected 5 0 0 0",
                     rank, busy, done, new_best);
        end
    endtask

    task automatic test_insert_sequence();
        int lat;
        int exp_t[6] = '{70, 55, 40, 0, 0, 0};
        do_reset();
        run_record(10'd40, lat);
        run_record(10'd70, lat);
        n_checks++;
        if (lat !== 7 || rank !== 3'd0 || new_best !== 1'b1) begin
            n_fail++;
            $display("FAIL insert70: lat=%0d rank=%0d nb=%b expected 7 0 1", lat, rank, new_best);
        end
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: done=%b busy=%b expected 0 0", done, busy);
        end
        run_record(10'd55, lat);
        n_checks++;
        if (lat !== 7 || rank !== 3'd1 || new_best !== 1'b0) begin
            n_fail++;
            $display("FAIL insert55: lat=%0d rank=%0d nb=%b expected 7 1 0", lat, rank, new_best);
        end
        for (int i = 0; i <= DEPTH; i++) begin
            rd_idx = IDX_W'(i);
            #1;
            n_checks++;
            if (rd_score !== SCORE_W'(exp_t[i])) begin
                n_fail++;
                $display("FAIL seq_tbl[%0d]: got %0d expected %0d", i, rd_score, exp_t[i]);
            end
        end
    endtask

    task automatic test_full_table();
        int lat;
        int exp_a[5] = '{90, 80, 70, 60, 50};
        int exp_b[5] = '{90, 85, 80, 70, 60};
        do_reset();
        run_record(10'd50, lat);
        run_record(10'd60, lat);
        run_record(10'd70, lat);
        run_record(10'd80, lat);
        run_record(10'd90, lat);
        run_record(10'd50, lat);
        n_checks++;
        if (lat !== 6 || rank !== 3'd5 || new_best !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_not_placed: lat=%0d rank=%0d nb=%b expected 6 5 0", lat, rank, new_best);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_idx = IDX_W'(i);
            #1;
            n_checks++;
            if (rd_score !== SCORE_W'(exp_a[i])) begin
                n_fail++;
                $display("FAIL full_tbl[%0d]: got %0d expected %0d", i, rd_score, exp_a[i]);
            end
        end
        run_record(10'd85, lat);
        n_checks++;
        if (lat !== 7 || rank !== 3'd1) begin
            n_fail++;
            $display("FAIL insert85: lat=%0d rank=%0d expected 7 1", lat, rank);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_idx = IDX_W'(i);
            #1;
            n_checks++;
            if (rd_score !== SCORE_W'(exp_b[i])) begin
                n_fail++;
                $display("FAIL evict_tbl[%0d]: got %0d expected %0d", i, rd_score, exp_b[i]);
            end
        end
    endtask

    task automatic test_held_record();
        int n_done;
        int exp_t[5] = '{33, 0, 0, 0, 0};
        do_reset();
        record = 1'b1;
        score  = 10'd33;
        n_done = 0;
        repeat (20) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        record = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL held_record_dones: got %0d expected 1", n_done);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_idx = IDX_W'(i);
            #1;
            n_checks++;
            if (rd_score !== SCORE_W'(exp_t[i])) begin
                n_fail++;
                $display("FAIL held_tbl[%0d]: got %0d expected %0d", i, rd_score, exp_t[i]);
            end
        end
    endtask

    task automatic test_busy_edge();
        int n_done;
        int exp_t[5] = '{44, 33, 0, 0, 0};
        record = 1'b1;
        score  = 10'd44;
        n_done = 0;
        tick();
        record = 1'b0;
        tick();
        record = 1'b1;
        score  = 10'd99;
        tick();
        record = 1'b0;
        repeat (25) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_edge: dones=%0d busy=%b expected 1 0", n_done, busy);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_idx = IDX_W'(i);
            #1;
            n_checks++;
            if (rd_score !== SCORE_W'(exp_t[i])) begin
                n_fail++;
                $display("FAIL busy_tbl[%0d]: got %0d expected %0d", i, rd_score, exp_t[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        do_reset();
        run_record(10'd40, lat);
        record = 1'b1;
        score  = 10'd70;
        tick();
        record = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rank !== 3'd5 || new_best !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_status: busy=%b done=%b rank=%0d nb=%b expected 0 0 5 0",
                     busy, done, rank, new_best);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_idx = IDX_W'(i);
            #1;
            n_checks++;
            if (rd_score !== 10'd0) begin
                n_fail++;
                $display("FAIL reset_mid_tbl[%0d]: got %0d expected 0", i, rd_score);
            end
        end
        run_record(10'd7, lat);
        rd_idx = 3'd0;
        #1;
        n_checks++;
        if (rd_score !== 10'd7 || lat !== 7 || rank !== 3'd0) begin
            n_fail++;
            $display("FAIL after_reset_insert: tbl0=%0d lat=%0d rank=%0d expected 7 7 0",
                     rd_score, lat, rank);
        end
    endtask

`ifdef SCORE_CLEAR_EN
    task automatic test_clear();
        int lat;
        int n_done;
        do_reset();
        run_record(10'd70, lat);
        clear  = 1'b1;
        record = 1'b1;
        score  = 10'd50;
        tick();
        clear  = 1'b0;
        n_done = 0;
        repeat (10) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        record = 1'b0;
        tick();
        n_checks++;
        if (n_done !== 0 || rank !== 3'd5 || new_best !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_beats_start: activity=%0d rank=%0d nb=%b expected 0 5 0",
                     n_done, rank, new_best);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_idx = IDX_W'(i);
            #1;
            n_checks++;
            if (rd_score !== 10'd0) begin
                n_fail++;
                $display("FAIL clear_tbl[%0d]: got %0d expected 0", i, rd_score);
            end
        end
        record = 1'b1;
        score  = 10'd20;
        tick();
        record = 1'b0;
        clear  = 1'b1;
        tick();
        tick();
        clear = 1'b0;
        lat   = 3;
        while (lat < 40 && done !== 1'b1) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== 7 || rank !== 3'd0) begin
            n_fail++;
            $display("FAIL clear_while_busy: lat=%0d rank=%0d expected 7 0", lat, rank);
        end
        tick();
        rd_idx = 3'd0;
        #1;
        n_checks++;
        if (rd_score !== 10'd20) begin
            n_fail++;
            $display("FAIL clear_while_busy_tbl: got %0d expected 20", rd_score);
        end
    endtask
`endif

    initial begin
        rst    = 1'b1;
        record = 1'b0;
        score  = '0;
        rd_idx = '0;
`ifdef SCORE_CLEAR_EN
        clear  = 1'b0;
`endif
        test_reset();
        test_insert_sequence();
        test_full_table();
        test_held_record();
        test_busy_edge();
        test_reset_mid();
`ifdef SCORE_CLEAR_EN
        test_clear();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
